bilinear_interp_pipe: RTL and testbench
=======================================

Name: bilinear_interp_pipe

Overview:
- Pipelined, multi-channel successor to the combinational bilinear interpolator in the flexible-downsampling datapath.
- Accepts one sample per cycle: a 2x2 pixel neighbourhood for CH channels, fixed-point x/y coordinates, a mode select and a sideband tag.
- Emits the interpolated pixel after a fixed 2-cycle latency, using valid/ready handshakes on both sides.
- Sits between the coordinate generator and the downsampled-token buffer.

Parameters:
- DW, 8, pixel width per channel (unsigned).
- IW, 8, integer bits of x/y.
- FW, 8, fractional bits of x/y and of the blend weights.
- CH, 4, channels processed in parallel.
- TAG_W, 8, sideband tag width, passed through unchanged.

Ports:
- clk  in  1  clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input accepted when in_valid && in_ready.
- in_x  in  IW+FW  x coordinate; only [FW-1:0] (dx) is used.
- in_y  in  IW+FW  y coordinate; only [FW-1:0] (dy) is used.
- in_mode  in  1  0 = bilinear, 1 = nearest-neighbour.
- in_p00  in  CH*DW  top-left pixels, channel c at [c*DW +: DW].
- in_p01  in  CH*DW  top-right pixels.
- in_p10  in  CH*DW  bottom-left pixels.
- in_p11  in  CH*DW  bottom-right pixels.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_pix  out  CH*DW  interpolated pixels.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Constants: S = 2^FW, H = 2^(FW-1).
- Lerp definition: lerp(a,b,w) = (a*(S-w) + b*w + H) >> FW, with intermediates at DW+FW+1 bits. The result is always <= max(a,b), so no saturation is needed and the result is truncated to DW.
- Weights:
  - Bilinear mode: wx = dx, wy = dy.
  - Nearest mode: wx = (dx >= H) ? S : 0, and wy likewise from dy. Ties round toward right/bottom.
- Stage 1, registered per channel: top = lerp(p00,p01,wx), bot = lerp(p10,p11,wx). The register also holds wy and tag.
- Stage 2, registered: pix = lerp(top,bot,wy). The register also holds tag.
- Valid flags s1_v and out_valid; enables:
  - en2 = !out_valid || out_ready
  - en1 = !s1_v || en2
  - in_ready = en1, which is combinational from out_ready and the valid flags.
- Stage 2 loads when en2: out_valid <= s1_v; the data register loads only when s1_v && en2.
- Stage 1 loads when en1: s1_v <= in_valid; data loads only on an accepted input.
- Latency: an input accepted in cycle t appears as out_valid=1 in cycle t+2 when out_ready is held high.
- Throughput: 1 sample/cycle. The pipeline holds at most 2 samples; no bubbles when out_ready=1.
- Backpressure: out_pix/out_tag are stable while out_valid && !out_ready. in_ready falls only when both stages are full and out_ready=0.
- Ordering: FIFO; tags always stay paired with their own data.
- Reset: s1_v=0, out_valid=0, out_pix=0, out_tag=0; in_ready is 1 in the first cycle after reset. Reset asserted mid-stream discards in-flight samples with no partial outputs. Inputs are ignored while rst=1.
- Simultaneous events: a new accept and an output handoff in the same cycle are legal and lossless.
- No unknowns: X on data with in_valid=0 must not propagate into any valid flag.

Decomposition:
- Package fdvit_interp_pkg holds:
  - the typedef enum logic {INTERP_BILINEAR=0, INTERP_NEAREST=1};
  - the LATENCY=2 localparam;
  - a weight-helper function that maps (dx, mode) to the weight.
- Sub-module interp_lerp (purely combinational, parameters DW and FW) computes one rounded lerp. It is instantiated 3*CH times via generate.

Test Plan (DW=8, FW=8, CH=2, out_ready=1 unless noted):
- Corner case: bilinear, dx=dy=0, p00={10,20}, p01={200,210} -> out_pix={10,20} exactly 2 cycles after accept, tag matches.
- Horizontal half: dx=0x80, dy=0, p00=100, p01=201 -> 151 ((12800+25728+128)>>8).
- Saddle: p00=0, p01=255, p10=255, p11=0, dx=dy=0x80 -> top=128, bot=128, out=128. Also all pixels 255 with dx=dy=0xFF -> 255 (no overflow).
- Nearest mode: dx=0x7F, dy=0x80, p10={77,88}, all other pixels 0 -> {77,88}; dx=0x80 instead selects p11.
- Backpressure: stream tags 1..6 back to back while out_ready=0 for cycles 3..7 -> in_ready=0 once 2 samples are held, out_pix stable while stalled, all 6 outputs delivered in order with no loss or duplication.
- Reset mid-stream: rst pulsed while 2 samples are in flight -> next cycle out_valid=0, out_pix=0, in_ready=1; the following input emerges 2 cycles after its accept.

Source files
------------

// File: rtl/bilinear_interp_pipe_pkg.sv
// fdvit_interp_pkg: interpolation mode enum, pipeline latency and blend-weight helper
package fdvit_interp_pkg;

    typedef enum logic {
        INTERP_BILINEAR = 1'b0,
        INTERP_NEAREST  = 1'b1
    } interp_mode_e;

    localparam int LATENCY = 2;

    // Fractional coordinate to blend weight (fw <= 16); nearest rounds ties up
    function automatic logic [16:0] interp_weight(input logic [15:0] dx, input int fw,
                                                  input interp_mode_e mode);
        logic [16:0] h;
        h = 17'(1) << (fw - 1);
        return (mode == INTERP_NEAREST) ? (({1'b0, dx} >= h) ? (17'(1) << fw) : 17'(0))
                                        : {1'b0, dx};
    endfunction

endpackage

// File: rtl/bilinear_interp_pipe_lerp.sv
// interp_lerp: rounded lerp y = (a*(S-w) + b*w + S/2) >> FW; ports a_i, b_i, w_i in [0,S], y_o
module interp_lerp #(
    parameter int DW = 8,
    parameter int FW = 8
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [FW:0]   w_i,
    output logic [DW-1:0] y_o
);

    localparam int AW = DW + FW + 1;

    logic [FW:0]   wa;
    logic [AW-1:0] acc;

    assign wa  = (FW+1)'(1 << FW) - w_i;
    assign acc = AW'(a_i) * AW'(wa) + AW'(b_i) * AW'(w_i) + AW'(1 << (FW - 1));
    assign y_o = DW'(acc >> FW);

endmodule

// File: rtl/bilinear_interp_pipe.sv
// bilinear_interp_pipe: 2-stage CH-channel bilinear/nearest interpolator; in_* valid/ready samples in, out_* valid/ready pixels out
module bilinear_interp_pipe
    import fdvit_interp_pkg::*;
#(
    parameter int DW    = 8,
    parameter int IW    = 8,
    parameter int FW    = 8,
    parameter int CH    = 4,
    parameter int TAG_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IW+FW-1:0]   in_x,
    input  logic [IW+FW-1:0]   in_y,
    input  logic               in_mode,
    input  logic [CH*DW-1:0]   in_p00,
    input  logic [CH*DW-1:0]   in_p01,
    input  logic [CH*DW-1:0]   in_p10,
    input  logic [CH*DW-1:0]   in_p11,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CH*DW-1:0]   out_pix,
    output logic [TAG_W-1:0]   out_tag
);

    logic [FW:0]        wx_d, wy_d, wy_q;
    logic [CH*DW-1:0]   top_d, bot_d, top_q, bot_q, pix_d, pix_q;
    logic [TAG_W-1:0]   tag1_q, tag2_q;
    logic               s1_v_q, out_valid_q, en1, en2;
    logic               unused_bits;

    assign unused_bits = ^{in_x[IW+FW-1:FW], in_y[IW+FW-1:FW]};

    assign wx_d = (FW+1)'(interp_weight(16'(in_x[FW-1:0]), FW, interp_mode_e'(in_mode)));
    assign wy_d = (FW+1)'(interp_weight(16'(in_y[FW-1:0]), FW, interp_mode_e'(in_mode)));

    assign en2      = !out_valid_q || out_ready;
    assign en1      = !s1_v_q || en2;
    assign in_ready = en1;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        interp_lerp #(.DW(DW), .FW(FW)) u_top (
            .a_i(in_p00[c*DW +: DW]), .b_i(in_p01[c*DW +: DW]), .w_i(wx_d), .y_o(top_d[c*DW +: DW])
        );
        interp_lerp #(.DW(DW), .FW(FW)) u_bot (
            .a_i(in_p10[c*DW +: DW]), .b_i(in_p11[c*DW +: DW]), .w_i(wx_d), .y_o(bot_d[c*DW +: DW])
        );
        interp_lerp #(.DW(DW), .FW(FW)) u_ver (
            .a_i(top_q[c*DW +: DW]), .b_i(bot_q[c*DW +: DW]), .w_i(wy_q), .y_o(pix_d[c*DW +: DW])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q      <= 1'b0;
            out_valid_q <= 1'b0;
            top_q       <= '0;
            bot_q       <= '0;
            wy_q        <= '0;
            tag1_q      <= '0;
            pix_q       <= '0;
            tag2_q      <= '0;
        end else begin
            if (en1)
                s1_v_q <= in_valid;
            if (en1 && in_valid) begin
                top_q  <= top_d;
                bot_q  <= bot_d;
                wy_q   <= wy_d;
                tag1_q <= in_tag;
            end
            if (en2)
                out_valid_q <= s1_v_q;
            if (en2 && s1_v_q) begin
                pix_q  <= pix_d;
                tag2_q <= tag1_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_pix   = pix_q;
    assign out_tag   = tag2_q;

endmodule

// File: tb/tb_bilinear_interp_pipe.sv
// tb_bilinear_interp_pipe: directed-vector bench for bilinear_interp_pipe with CH=2
module tb_bilinear_interp_pipe;

    localparam int DW = 8, IW = 8, FW = 8, CH = 2, TAG_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_ready, in_mode, out_valid, out_ready;
    logic [IW+FW-1:0]   in_x, in_y;
    logic [CH*DW-1:0]   in_p00, in_p01, in_p10, in_p11, out_pix;
    logic [TAG_W-1:0]   in_tag, out_tag;
    int                 total = 0, bad = 0;

    always #5 clk = ~clk;

    bilinear_interp_pipe #(.DW(DW), .IW(IW), .FW(FW), .CH(CH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .in_mode(in_mode), .in_p00(in_p00), .in_p01(in_p01), .in_p10(in_p10), .in_p11(in_p11),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
        .out_tag(out_tag)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pk(input int c0, input int c1);
        return {8'(c1), 8'(c0)};
    endfunction

    task automatic drive(input logic m, input logic [7:0] dx, input logic [7:0] dy,
                         input logic [15:0] p00, input logic [15:0] p01,
                         input logic [15:0] p10, input logic [15:0] p11, input logic [7:0] tag);
        in_valid = 1'b1;
        in_mode  = m;
        in_x     = {8'h05, dx};
        in_y     = {8'h0A, dy};
        in_p00   = p00;
        in_p01   = p01;
        in_p10   = p10;
        in_p11   = p11;
        in_tag   = tag;
    endtask

    task automatic run1(input string name, input logic m, input logic [7:0] dx, input logic [7:0] dy,
                        input logic [15:0] p00, input logic [15:0] p01,
                        input logic [15:0] p10, input logic [15:0] p11,
                        input logic [7:0] tag, input logic [15:0] exp);
        drive(m, dx, dy, p00, p01, p10, p11, tag);
        #1;
        chk({name, "_rdy"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        in_p00   = 'x;
        in_tag   = 'x;
        chk({name, "_lat1"}, 64'(out_valid), 64'd0);
        step();
        chk({name, "_vld"}, 64'(out_valid), 64'd1);
        chk({name, "_pix"}, 64'(out_pix), 64'(exp));
        chk({name, "_tag"}, 64'(out_tag), 64'(tag));
        step();
    endtask

    initial begin
        int sent, got_cnt, low_cnt;
        logic acc_in, acc_out, prev_stall;
        logic [15:0] prev_pix;
        logic [7:0]  prev_tag, t;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 8'h0, 8'h0, '0, '0, '0, '0, '0);
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_vld", 64'(out_valid), 64'd0);
        chk("rst_pix", 64'(out_pix), 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
        chk("rst_rdy", 64'(in_ready), 64'd1);

        run1("corner", 1'b0, 8'h00, 8'h00, pk(10, 20), pk(200, 210), pk(50, 60), pk(70, 80), 8'h11, pk(10, 20));
        run1("hhalf", 1'b0, 8'h80, 8'h00, pk(100, 0), pk(201, 255), pk(0, 0), pk(0, 0), 8'h22, pk(151, 128));
        run1("saddle", 1'b0, 8'h80, 8'h80, pk(0, 0), pk(255, 255), pk(255, 255), pk(0, 0), 8'h33, pk(128, 128));
        run1("max", 1'b0, 8'hFF, 8'hFF, pk(255, 255), pk(255, 255), pk(255, 255), pk(255, 255), 8'h44, pk(255, 255));
        run1("nn_bl", 1'b1, 8'h7F, 8'h80, pk(0, 0), pk(0, 0), pk(77, 88), pk(0, 0), 8'h55, pk(77, 88));
        run1("nn_br", 1'b1, 8'h80, 8'h80, pk(0, 0), pk(0, 0), pk(77, 88), pk(33, 44), 8'h66, pk(33, 44));
        run1("bl_mix", 1'b0, 8'h7F, 8'h80, pk(0, 0), pk(0, 0), pk(77, 88), pk(0, 0), 8'h77, pk(20, 22));

        // backpressure: tags 1..6 back to back, out_ready low for cycles 3..7
        sent = 0;
        got_cnt = 0;
        low_cnt = 0;
        prev_stall = 1'b0;
        prev_pix = '0;
        prev_tag = '0;
        for (int k = 0; k < 30; k++) begin
            out_ready = !(k >= 3 && k <= 7);
            t = 8'(sent + 1);
            drive(1'b0, 8'h00, 8'h00, pk(t * 10, t * 10 + 1), 16'hFFFF, 16'hFFFF, 16'hFFFF, t);
            in_valid = (sent < 6);
            #1;
            if (k == 2) chk("bp_rdy_hi", 64'(in_ready), 64'd1);
            if (k == 3) chk("bp_rdy_lo", 64'(in_ready), 64'd0);
            if (!in_ready) low_cnt++;
            if (prev_stall) begin
                chk("bp_stall_vld", 64'(out_valid), 64'd1);
                chk("bp_stall_pix", 64'(out_pix), 64'(prev_pix));
                chk("bp_stall_tag", 64'(out_tag), 64'(prev_tag));
            end
            acc_in  = in_valid && in_ready;
            acc_out = out_valid && out_ready;
            if (acc_out) begin
                got_cnt++;
                chk("bp_tag", 64'(out_tag), 64'(got_cnt));
                chk("bp_pix", 64'(out_pix), 64'(pk(got_cnt * 10, got_cnt * 10 + 1)));
            end
            prev_stall = out_valid && !out_ready;
            prev_pix = out_pix;
            prev_tag = out_tag;
            step();
            if (acc_in) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_sent", 64'(sent), 64'd6);
        chk("bp_got", 64'(got_cnt), 64'd6);
        chk("bp_low", 64'(low_cnt), 64'd5);

        // reset with two samples in flight
        drive(1'b0, 8'h00, 8'h00, pk(1, 2), '0, '0, '0, 8'hA1);
        step();
        drive(1'b0, 8'h00, 8'h00, pk(3, 4), '0, '0, '0, 8'hA2);
        step();
        chk("mid_full", 64'(out_valid), 64'd1);
        drive(1'b0, 8'h00, 8'h00, pk(5, 6), '0, '0, '0, 8'hEE);
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mid_vld", 64'(out_valid), 64'd0);
        chk("mid_pix", 64'(out_pix), 64'd0);
        chk("mid_tag", 64'(out_tag), 64'd0);
        chk("mid_rdy", 64'(in_ready), 64'd1);
        step();
        chk("mid_ign", 64'(out_valid), 64'd0);
        run1("post_rst", 1'b0, 8'h40, 8'h00, pk(0, 100), pk(200, 100), pk(0, 0), pk(0, 0), 8'hC3, pk(50, 100));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
